// File: rtl/alu_seq_exec.sv
// EX-stage ALU: decodes ALU_op/fn_code into a 5-bit control code and executes it behind valid/ready handshakes.
// Shifts step one bit per cycle unless ALU_SEQ_BARREL_EN is defined, which selects a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | no operation held, ready for a request
// SHIFT | iterative shift in progress, cnt_q bits still to move
// DONE  | result and flags valid, held until out_ready
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALU_op,
    input  logic [5:0]         fn_code,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               zero,
    output logic               sign,
    output logic               illegal,
    output logic [4:0]         alu_control_signal
);

    localparam logic [4:0] C_NONE = 5'd0;
    localparam logic [4:0] C_ADD  = 5'd1;
    localparam logic [4:0] C_COMP = 5'd2;
    localparam logic [4:0] C_AND  = 5'd3;
    localparam logic [4:0] C_XOR  = 5'd4;
    localparam logic [4:0] C_SLL  = 5'd5;
    localparam logic [4:0] C_SRL  = 5'd6;
    localparam logic [4:0] C_SRA  = 5'd7;
    localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d, zero_q, zero_d, sign_q, sign_d, illegal_q, illegal_d;
    logic [4:0]         code_q, code_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [4:0]         dec_code;
    logic               dec_var, dec_shift, go_iter, accept;
    logic [SHAMT_W-1:0] dec_amt;
    logic [WIDTH:0]     sum, sll_ext, srl_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]   fast_res, step_res;
    logic               fast_c, step_c;

    always_comb begin
        dec_code = C_NONE;
        dec_var  = 1'b0;
        if (ALU_op == 4'b0001) begin
            case (fn_code)
                6'b000000: dec_code = C_ADD;
                6'b000010: dec_code = C_COMP;
                6'b000011: dec_code = C_AND;
                6'b000100: dec_code = C_XOR;
                6'b000101: dec_code = C_SLL;
                6'b000110: dec_code = C_SRL;
                6'b000111: dec_code = C_SRA;
                6'b001000: begin dec_code = C_SLL; dec_var = 1'b1; end
                6'b001001: begin dec_code = C_SRL; dec_var = 1'b1; end
                6'b001010: begin dec_code = C_SRA; dec_var = 1'b1; end
                default:   dec_code = C_NONE;
            endcase
        end else if (ALU_op == 4'b0010) begin
            case (fn_code)
                6'b000001: dec_code = C_ADD;
                6'b000010: dec_code = C_COMP;
                default:   dec_code = C_NONE;
            endcase
        end
        dec_shift = (dec_code == C_SLL) || (dec_code == C_SRL) || (dec_code == C_SRA);
        dec_amt   = dec_var ? op_b[SHAMT_W-1:0] : shamt;
    end

    // Extended shifts keep the last bit shifted out in the extra position (0 when the amount is 0).
    always_comb begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        sll_ext  = {1'b0, op_a} << dec_amt;
        srl_ext  = {op_a, 1'b0} >> dec_amt;
        sra_ext  = $signed({op_a, 1'b0}) >>> dec_amt;
        fast_res = '0;
        fast_c   = 1'b0;
        case (dec_code)
            C_ADD:  begin fast_res = sum[WIDTH-1:0];     fast_c = sum[WIDTH];     end
            C_COMP: begin fast_res = -op_a;              fast_c = (op_a == '0);   end
            C_AND:  fast_res = op_a & op_b;
            C_XOR:  fast_res = op_a ^ op_b;
            C_SLL:  begin fast_res = sll_ext[WIDTH-1:0]; fast_c = sll_ext[WIDTH]; end
            C_SRL:  begin fast_res = srl_ext[WIDTH:1];   fast_c = srl_ext[0];     end
            C_SRA:  begin fast_res = sra_ext[WIDTH:1];   fast_c = sra_ext[0];     end
            default: ;
        endcase
    end

    always_comb begin
        step_res = acc_q;
        step_c   = 1'b0;
        case (code_q)
            C_SLL: begin step_res = {acc_q[WIDTH-2:0], 1'b0};          step_c = acc_q[WIDTH-1]; end
            C_SRL: begin step_res = {1'b0, acc_q[WIDTH-1:1]};          step_c = acc_q[0];       end
            C_SRA: begin step_res = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; step_c = acc_q[0];       end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_BARREL_EN
    assign go_iter = 1'b0;
`else
    assign go_iter = dec_shift && (dec_amt != '0);
`endif

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        sign_d    = sign_q;
        illegal_d = illegal_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        case (state_q)
            SHIFT: begin
                acc_d   = step_res;
                carry_d = step_c;
                cnt_d   = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = DONE;
                    zero_d  = (step_res == '0);
                    sign_d  = step_res[WIDTH-1];
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: ;
        endcase
        // A new accept overrides the DONE->IDLE return so back-to-back ops never bubble.
        if (accept) begin
            code_d    = dec_code;
            illegal_d = (dec_code == C_NONE);
            if (go_iter) begin
                state_d = SHIFT;
                acc_d   = op_a;
                cnt_d   = dec_amt;
                carry_d = 1'b0;
            end else begin
                state_d = DONE;
                acc_d   = fast_res;
                carry_d = fast_c;
                zero_d  = (fast_res == '0);
                sign_d  = fast_res[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            sign_q    <= 1'b0;
            illegal_q <= 1'b0;
            code_q    <= C_NONE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            sign_q    <= sign_d;
            illegal_q <= illegal_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid          = (state_q == DONE);
    assign result             = acc_q;
    assign carry              = carry_q;
    assign zero               = zero_q;
    assign sign               = sign_q;
    assign illegal            = illegal_q;
    assign alu_control_signal = code_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized self-checking bench for alu_seq_exec against a behavioural model of the decode/execute rules.
module tb_alu_seq_exec;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic         carry, zero, sign, illegal;
    logic [3:0]   alu_op;
    logic [5:0]   fn_code;
    logic [W-1:0] op_a, op_b, result;
    logic [4:0]   shamt, code;

    always #5 clk = ~clk;

    alu_seq_exec #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_op(alu_op), .fn_code(fn_code), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
        .zero(zero), .sign(sign), .illegal(illegal), .alu_control_signal(code)
    );

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        ill;
        logic [4:0]  code;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    bit   mon_en = 0, rand_bp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        bit   var_sh = 0;
        int   k;
        logic [32:0] s;
        e.code = 5'd0; e.res = 32'd0; e.c = 1'b0; e.lat = 1;
        if (op == 4'b0001) begin
            case (fn)
                6'd0:  e.code = 5'd1;
                6'd2:  e.code = 5'd2;
                6'd3:  e.code = 5'd3;
                6'd4:  e.code = 5'd4;
                6'd5:  e.code = 5'd5;
                6'd6:  e.code = 5'd6;
                6'd7:  e.code = 5'd7;
                6'd8:  begin e.code = 5'd5; var_sh = 1; end
                6'd9:  begin e.code = 5'd6; var_sh = 1; end
                6'd10: begin e.code = 5'd7; var_sh = 1; end
                default: e.code = 5'd0;
            endcase
        end else if (op == 4'b0010) begin
            if (fn == 6'd1) e.code = 5'd1;
            else if (fn == 6'd2) e.code = 5'd2;
        end
        e.ill = (e.code == 5'd0);
        k = var_sh ? int'(b[4:0]) : int'(sh);
        case (e.code)
            5'd1: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.c = s[32]; end
            5'd2: begin e.res = 32'd0 - a; e.c = (a == 32'd0); end
            5'd3: e.res = a & b;
            5'd4: e.res = a ^ b;
            5'd5: begin e.res = a << k; e.c = (k == 0) ? 1'b0 : a[32-k]; end
            5'd6: begin e.res = a >> k; e.c = (k == 0) ? 1'b0 : a[k-1]; end
            5'd7: begin e.res = $unsigned($signed(a) >>> k); e.c = (k == 0) ? 1'b0 : a[k-1]; end
            default: ;
        endcase
`ifndef ALU_SEQ_BARREL_EN
        if (e.code >= 5'd5 && e.code <= 5'd7 && k > 0) e.lat = 1 + k;
`endif
        return e;
    endfunction

    // Compare process: predicts out_valid/in_ready every cycle and checks held results against the model.
    always @(negedge clk) begin
        bit busy, ev;
        cyc++;
        if (!rst) begin
            exp_q.delete();
        end else if (mon_en) begin
            busy = (exp_q.size() != 0);
            ev   = busy && (cyc - acc_cyc >= exp_q[0].lat);
            chk("mon_out_valid", 32'(out_valid), 32'(ev));
            chk("mon_in_ready", 32'(in_ready), 32'(!busy || (ev && out_ready)));
            if (ev && out_valid) begin
                chk("mon_result", result, exp_q[0].res);
                chk("mon_carry", 32'(carry), 32'(exp_q[0].c));
                chk("mon_zero", 32'(zero), 32'(exp_q[0].res == 32'd0));
                chk("mon_sign", 32'(sign), 32'(exp_q[0].res[31]));
                chk("mon_illegal", 32'(illegal), 32'(exp_q[0].ill));
                chk("mon_code", 32'(code), 32'(exp_q[0].code));
            end
            if (ev && out_ready) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                exp_q.push_back(model(alu_op, fn_code, op_a, op_b, shamt));
                acc_cyc = cyc;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit ordy, output int waited);
        @(posedge clk); #1;
        alu_op = op; fn_code = fn; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
        if (!rand_bp) out_ready = ordy;
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL issue_timeout: in_ready stayed %b expected 1 at %0t", in_ready, $time);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (out_valid) return;
        end
        n_tests++; n_fail++;
        $display("FAIL wait_valid_timeout: out_valid %b expected 1 at %0t", out_valid, $time);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_carry"}, 32'(carry), 32'd0);
        chk({tag, "_zero"}, 32'(zero), 32'd0);
        chk({tag, "_sign"}, 32'(sign), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, waited, sra_lat, guard;
        logic [5:0] fns1 [10];
        logic [3:0] op;
        logic [5:0] fn;
        fns1 = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10};
`ifdef ALU_SEQ_BARREL_EN
        sra_lat = 1;
`else
        sra_lat = 5;
`endif
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 4'd0; fn_code = 6'd0; op_a = '0; op_b = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1;

        issue(4'b0001, 6'b000000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b1, waited);
        wait_valid(lat);
        chk("add_ovf_lat", 32'(lat), 32'd1);
        chk("add_ovf_result", result, 32'h0);
        chk("add_ovf_carry", 32'(carry), 32'd1);
        chk("add_ovf_zero", 32'(zero), 32'd1);
        chk("add_ovf_code", 32'(code), 32'd1);

        issue(4'b0010, 6'b000001, 32'd5, 32'hFFFF_FFFD, 5'd0, 1'b1, waited);
        wait_valid(lat);
        chk("addi_result", result, 32'd2);
        chk("addi_carry", 32'(carry), 32'd1);

        issue(4'b0010, 6'b000010, 32'd3, 32'd0, 5'd0, 1'b1, waited);
        wait_valid(lat);
        chk("compi_result", result, 32'hFFFF_FFFD);
        chk("compi_sign", 32'(sign), 32'd1);
        chk("compi_code", 32'(code), 32'd2);

        issue(4'b0001, 6'b000111, 32'h8000_0000, 32'd0, 5'd4, 1'b1, waited);
        wait_valid(lat);
        chk("sra_lat", 32'(lat), 32'(sra_lat));
        chk("sra_result", result, 32'hF800_0000);
        chk("sra_carry", 32'(carry), 32'd0);
        chk("sra_code", 32'(code), 32'd7);

        issue(4'b0001, 6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b1, waited);
        wait_valid(lat);
        chk("illegal_lat", 32'(lat), 32'd1);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_result", result, 32'd0);
        chk("illegal_code", 32'(code), 32'd0);

        issue(4'b0001, 6'b000100, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 1'b0, waited);
        wait_valid(lat);
        chk("xor_result", result, 32'h0F0F_F0F0);
        chk("xor_illegal", 32'(illegal), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'h0F0F_F0F0);
        end
        issue(4'b0001, 6'b000011, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 1'b1, waited);
        chk("b2b_accept_wait", 32'(waited), 32'd1);
        wait_valid(lat);
        chk("b2b_lat", 32'(lat), 32'd1);
        chk("and_result", result, 32'hF0F0_0000);

        issue(4'b0001, 6'b000101, 32'h0000_0001, 32'd0, 5'd20, 1'b1, waited);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midop_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_abort_out_valid", 32'(out_valid), 32'd0);
            chk("post_abort_in_ready", 32'(in_ready), 32'd1);
        end

        rand_bp = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin op = 4'b0001; fn = fns1[$urandom_range(0, 9)]; end
                6, 7: begin op = 4'b0010; fn = 6'($urandom_range(1, 2)); end
                default: begin op = 4'($urandom); fn = 6'($urandom); end
            endcase
            issue(op, fn, pick_operand(), pick_operand(), 5'($urandom), 1'b1, waited);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_bp = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
